// File: rtl/prbs_checker_if.sv
// Serial link bundle between a PRBS bit source and prbs_checker.
// master drives the received bit stream; slave (the checker) returns status and counters.
interface prbs_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic             lock_lost;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output din, din_valid, clr_cnt,
    input  locked, err, lock_lost, err_cnt, bit_cnt
  );

  modport slave (
    input  din, din_valid, clr_cnt,
    output locked, err, lock_lost, err_cnt, bit_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: fill history, search for LOCK_CNT matches, then check.
// Optional bit counter for BER measurement is built only when PRBS_CHK_BITCNT_EN is defined.
module prbs_checker #(
  parameter int unsigned N          = 7,
  parameter logic [N-1:0] POLY      = 7'b1100000,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic           clk,
  input logic           reset,
  prbs_checker_if.slave bus
);

  localparam int unsigned FillW  = $clog2(N + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    StFill,
    StSearch,
    StLocked
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        hist_q, hist_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [MissW-1:0]    miss_q, miss_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                lost_q, lost_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                pred;
  logic                hit;

  // hist_q[k] holds the bit received k+1 valid bits ago.
  assign pred = ^(hist_q & POLY);
  assign hit  = (bus.din == pred);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    lost_d  = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        StFill: begin
          hist_d = {hist_q[N-2:0], bus.din};
          if (fill_q == FillW'(N - 1)) begin
            state_d = StSearch;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        StSearch: begin
          hist_d = {hist_q[N-2:0], bus.din};
          if (hit) begin
            if (match_q == MatchW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          // Self-feeding prediction keeps a line error from corrupting the history.
          hist_d = {hist_q[N-2:0], pred};
          if (!hit) begin
            err_d = 1'b1;
            if (miss_q == MissW'(UNLOCK_CNT - 1)) begin
              lost_d  = 1'b1;
              state_d = StFill;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = StFill;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == StLocked);
  end

  // A new error in the same cycle as a clear leaves a count of one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d) begin
      if (bus.clr_cnt) begin
        err_cnt_d = CNT_W'(1);
      end else if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (bus.clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFill;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.lock_lost = lost_q;
  assign bus.err_cnt   = err_cnt_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             checked;

  assign checked = bus.din_valid && (state_q == StLocked);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (checked) begin
      if (bus.clr_cnt) begin
        bit_cnt_d = CNT_W'(1);
      end else if (!(&bit_cnt_q)) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (bus.clr_cnt) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.bit_cnt = bit_cnt_q;
`else
  assign bus.bit_cnt = '0;
`endif

endmodule
